// File: rtl/pause_counter_pkg.sv
// Shared defaults, pause state type and binary-to-BCD helper for the pause counter.
package pause_counter_pkg;

   localparam int DIV_DEF        = 100;
   localparam int DEB_CYCLES_DEF = 20;
   localparam int MAX_COUNT_DEF  = 19;
   localparam int CNT_W_DEF      = 5;
   localparam int BCD_W          = 4;

   typedef enum logic {
      ST_RUN   = 1'b0,
      ST_PAUSE = 1'b1
   } pause_state_e;

   // Shift-add-3 over the low nbits of value; result is {tens, ones}.
   function automatic logic [2*BCD_W-1:0] bin_to_bcd(input logic [7:0] value, input int nbits);
      logic [2*BCD_W-1:0] bcd;
      bcd = 8'd0;
      for (int i = 7; i >= 0; i--) begin
         if (i < nbits) begin
            if (bcd[3:0] >= 4'd5) begin
               bcd[3:0] = bcd[3:0] + 4'd3;
            end else begin
               bcd[3:0] = bcd[3:0];
            end
            if (bcd[7:4] >= 4'd5) begin
               bcd[7:4] = bcd[7:4] + 4'd3;
            end else begin
               bcd[7:4] = bcd[7:4];
            end
            bcd = {bcd[6:0], value[i]};
         end else begin
            bcd = bcd;
         end
      end
      return bcd;
   endfunction

endpackage

// File: rtl/btn_debouncer.sv
// Button front-end: 2-flop synchronizer, stability counter, debounced level and rising-edge pulse.
module btn_debouncer #(
   parameter int DEB_CYCLES = 20
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_in,
   output logic btn_level,
   output logic btn_pulse
);

   localparam int DEB_W = $clog2(DEB_CYCLES + 1);
   localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);
   localparam logic [DEB_W-1:0] DEB_ONE  = DEB_W'(1);

   logic             r_sync1;
   logic             r_sync2;
   logic             r_level;
   logic             r_pulse;
   logic [DEB_W-1:0] r_stab_cnt;

   // A new level is accepted only after DEB_CYCLES consecutive disagreeing samples.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sync1    <= 1'b0;
         r_sync2    <= 1'b0;
         r_level    <= 1'b0;
         r_pulse    <= 1'b0;
         r_stab_cnt <= {DEB_W{1'b0}};
      end else begin
         r_sync1 <= btn_in;
         r_sync2 <= r_sync1;
         r_pulse <= 1'b0;
         if (r_sync2 == r_level) begin
            r_stab_cnt <= {DEB_W{1'b0}};
         end else if (r_stab_cnt == DEB_LAST) begin
            r_level    <= r_sync2;
            r_stab_cnt <= {DEB_W{1'b0}};
            r_pulse    <= r_sync2;
         end else begin
            r_stab_cnt <= r_stab_cnt + DEB_ONE;
         end
      end
   end

   assign btn_level = r_level;
   assign btn_pulse = r_pulse;

endmodule

// File: rtl/pause_counter_bcd.sv
// Pausable wrapping display counter with tick divider and BCD outputs.
// Define BCD_REG_EN to register the BCD digits (one clk behind count).
module pause_counter_bcd
   import pause_counter_pkg::*;
#(
   parameter int DIV        = DIV_DEF,
   parameter int DEB_CYCLES = DEB_CYCLES_DEF,
   parameter int MAX_COUNT  = MAX_COUNT_DEF,
   parameter int CNT_W      = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             btn_in,
   output logic             tick,
   output logic             btn_level,
   output logic             btn_pulse,
   output logic             paused,
   output logic [CNT_W-1:0] count,
   output logic [BCD_W-1:0] bcd_tens,
   output logic [BCD_W-1:0] bcd_ones
);

   localparam int DIV_W = $clog2(DIV);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
   localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
   localparam logic [CNT_W-1:0] MAX_C    = CNT_W'(MAX_COUNT);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic [DIV_W-1:0]   r_div_cnt;
   logic               w_tick;
   logic               w_btn_level;
   logic               w_btn_pulse;
   pause_state_e       r_pause_state;
   logic [CNT_W-1:0]   r_count;
   logic [2*BCD_W-1:0] w_bcd;

   btn_debouncer #(
      .DEB_CYCLES(DEB_CYCLES)
   ) u_debouncer (
      .clk      (clk),
      .rst      (rst),
      .btn_in   (btn_in),
      .btn_level(w_btn_level),
      .btn_pulse(w_btn_pulse)
   );

   assign w_tick = (r_div_cnt == DIV_LAST);

   // Free-running divider; the tick cycle is the last state before wrap.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_div_cnt <= {DIV_W{1'b0}};
      end else if (w_tick) begin
         r_div_cnt <= {DIV_W{1'b0}};
      end else begin
         r_div_cnt <= r_div_cnt + DIV_ONE;
      end
   end

   // Count sees the pause state before any toggle in the same cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pause_state <= ST_RUN;
         r_count       <= MAX_C;
      end else begin
         if (w_tick && (r_pause_state == ST_RUN)) begin
            r_count <= (r_count >= MAX_C) ? {CNT_W{1'b0}} : r_count + CNT_ONE;
         end else begin
            r_count <= r_count;
         end
         if (w_btn_pulse) begin
            r_pause_state <= (r_pause_state == ST_RUN) ? ST_PAUSE : ST_RUN;
         end else begin
            r_pause_state <= r_pause_state;
         end
      end
   end

   assign w_bcd = bin_to_bcd(8'(r_count), CNT_W);

`ifdef BCD_REG_EN
   logic [BCD_W-1:0] r_bcd_tens;
   logic [BCD_W-1:0] r_bcd_ones;

   // Registered digits; reset matches the digits of the reset count.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_bcd_tens <= 4'd1;
         r_bcd_ones <= 4'd9;
      end else begin
         r_bcd_tens <= w_bcd[7:4];
         r_bcd_ones <= w_bcd[3:0];
      end
   end

   assign bcd_tens = r_bcd_tens;
   assign bcd_ones = r_bcd_ones;
`else
   assign bcd_tens = w_bcd[7:4];
   assign bcd_ones = w_bcd[3:0];
`endif

   assign tick      = w_tick;
   assign btn_level = w_btn_level;
   assign btn_pulse = w_btn_pulse;
   assign paused    = (r_pause_state == ST_PAUSE);
   assign count     = r_count;

endmodule

// File: tb/tb_pause_counter_bcd.sv
// Self-checking bench for pause_counter_bcd with DIV=4, DEB_CYCLES=4.
module tb_pause_counter_bcd;

   localparam int DIV  = 4;
   localparam int DEB  = 4;
   localparam int MAXC = 19;
   localparam int CW   = 5;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          btn_in = 1'b0;
   logic          tick;
   logic          btn_level;
   logic          btn_pulse;
   logic          paused;
   logic [CW-1:0] count;
   logic [3:0]    bcd_tens;
   logic [3:0]    bcd_ones;

   int n_tests = 0;
   int n_fail  = 0;
   int n_pulses = 0;

   // model state
   int m_edges, m_count, m_level, m_pulse, m_paused, m_rt, m_ro;
   int dly[$];
   int hist[$];

   pause_counter_bcd #(
      .DIV(DIV), .DEB_CYCLES(DEB), .MAX_COUNT(MAXC), .CNT_W(CW)
   ) dut (
      .clk(clk), .rst(rst), .btn_in(btn_in), .tick(tick),
      .btn_level(btn_level), .btn_pulse(btn_pulse), .paused(paused),
      .count(count), .bcd_tens(bcd_tens), .bcd_ones(bcd_ones)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic m_reset();
      m_edges = 0; m_count = MAXC; m_level = 0; m_pulse = 0; m_paused = 0;
      m_rt = 1; m_ro = 9;
      dly = {0, 0};
      hist = {};
   endtask

   // One clock edge of the specified behaviour, from pre-edge state and input.
   task automatic m_step(input int b);
      int tick_now, sample, all_diff, new_level;
      tick_now = ((m_edges % DIV) == DIV - 1);
      sample = dly.pop_front();
      dly.push_back(b);
      hist.push_back(sample);
      if (hist.size() > DEB) void'(hist.pop_front());
      all_diff = (hist.size() == DEB);
      foreach (hist[i]) if (hist[i] == m_level) all_diff = 0;
      new_level = all_diff ? 1 - m_level : m_level;
      m_rt = m_count / 10;
      m_ro = m_count % 10;
      if (tick_now && !m_paused) m_count = (m_count >= MAXC) ? 0 : m_count + 1;
      if (m_pulse) m_paused = 1 - m_paused;
      m_pulse = (new_level == 1 && m_level == 0);
      m_level = new_level;
      m_edges++;
   endtask

   initial begin
      m_reset();
      forever begin
         @(posedge clk or posedge rst);
         if (rst) m_reset();
         else m_step(int'(btn_in));
      end
   end

   // Compare every output against the model on each falling edge.
   initial begin
      forever begin
         @(negedge clk);
         if (!rst) begin
            check("tick", int'(tick), ((m_edges % DIV) == DIV - 1) ? 1 : 0);
            check("btn_level", int'(btn_level), m_level);
            check("btn_pulse", int'(btn_pulse), m_pulse);
            check("paused", int'(paused), m_paused);
            check("count", int'(count), m_count);
`ifdef BCD_REG_EN
            check("bcd_tens", int'(bcd_tens), m_rt);
            check("bcd_ones", int'(bcd_ones), m_ro);
`else
            check("bcd_tens", int'(bcd_tens), m_count / 10);
            check("bcd_ones", int'(bcd_ones), m_count % 10);
`endif
            if (btn_pulse) n_pulses++;
         end
      end
   end

   task automatic wait_neg(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic press(input int hold, input int after);
      btn_in = 1'b1;
      wait_neg(hold);
      btn_in = 1'b0;
      wait_neg(after);
   endtask

   initial begin
      int p0, held, found;
      wait_neg(3);
      check("rst_count", int'(count), 19);
      check("rst_tens", int'(bcd_tens), 1);
      check("rst_ones", int'(bcd_ones), 9);
      check("rst_paused", int'(paused), 0);
      check("rst_tick", int'(tick), 0);
      rst = 1'b0;

      wait_neg(3);
      check("first_tick", int'(tick), 1);
      check("pre_first_count", int'(count), 19);
      wait_neg(1);
      check("first_wrap", int'(count), 0);
      check("tick_low", int'(tick), 0);
      wait_neg(40);
      check("count10", int'(count), 10);
`ifdef BCD_REG_EN
      check("reg_lag_tens", int'(bcd_tens), 0);
      check("reg_lag_ones", int'(bcd_ones), 9);
      wait_neg(1);
      check("reg_tens10", int'(bcd_tens), 1);
      check("reg_ones10", int'(bcd_ones), 0);
      wait_neg(35);
`else
      check("tens10", int'(bcd_tens), 1);
      check("ones10", int'(bcd_ones), 0);
      wait_neg(36);
`endif
      check("count19", int'(count), 19);
      wait_neg(4);
      check("wrap_19_0", int'(count), 0);

      press(2, 10);
      check("glitch_level", int'(btn_level), 0);
      check("glitch_pulses", n_pulses, 0);
      check("glitch_paused", int'(paused), 0);

      p0 = n_pulses;
      press(10, 10);
      check("press_one_pulse", n_pulses - p0, 1);
      check("press_paused", int'(paused), 1);
      held = int'(count);
      wait_neg(20);
      check("frozen", int'(count), held);

      press(10, 10);
      check("resume_paused", int'(paused), 0);
      wait_neg(8);
      check("resume_moving", (int'(count) != held) ? 1 : 0, 1);

      found = 0;
      for (int i = 0; i < 200 && found == 0; i++) begin
         @(negedge clk);
         if (tick && count == 5 && !paused) found = 1;
      end
      check("find_count5", found, 1);
      if (found == 1) begin
         wait_neg(2);
         btn_in = 1'b1;
         wait_neg(6);
         check("coinc_tick", int'(tick), 1);
         check("coinc_pulse", int'(btn_pulse), 1);
         check("coinc_count7", int'(count), 7);
         wait_neg(1);
         check("coinc_count8", int'(count), 8);
         check("coinc_paused", int'(paused), 1);
      end
      btn_in = 1'b1;
      wait_neg(10);

      #2;
      rst = 1'b1;
      #1;
      check("mid_rst_count", int'(count), 19);
      check("mid_rst_tens", int'(bcd_tens), 1);
      check("mid_rst_ones", int'(bcd_ones), 9);
      check("mid_rst_paused", int'(paused), 0);
      check("mid_rst_tick", int'(tick), 0);
      check("mid_rst_level", int'(btn_level), 0);
      wait_neg(2);
      btn_in = 1'b0;
      rst = 1'b0;
      wait_neg(30);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
